twod_counter_digit: RTL and testbench

- One bit-digit of a dual-rail (NCL-style) ripple counter: each DATA wavefront on carryin adds the carry to a stored digit, emits the sum and carry-out digits, then returns to NULL.
- Stages chain through carryout/carryincomp; N stages form an N-bit counter.
- Handshakes are four-phase DATA/NULL, modelled synchronously on one clock.
- Includes two leaf cells used by the surrounding chain: the TH12 completion OR and the THnotN inverting source.

---
 rtl/twod_counter_digit_pkg.sv | 27 ++
 rtl/twod_counter_digit_cells.sv | 23 ++
 rtl/twod_counter_digit.sv | 79 +++++++
 tb/tb_twod_counter_digit.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/twod_counter_digit_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | twod_counter_digit_pkg                                               |
// | Dual-rail encodings, phase type and rail helpers for the counter.    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package twod_counter_digit_pkg;

    localparam logic [1:0] NULL_V = 2'b00;
    localparam logic [1:0] D0     = 2'b01;
    localparam logic [1:0] D1     = 2'b10;

    typedef enum logic [0:0] {
        NULL_PH = 1'b0,
        DATA_PH = 1'b1
    } phase_t;

    function automatic logic is_data(input logic [1:0] rails);
        return (rails == D0) || (rails == D1);
    endfunction

    function automatic logic rail_val(input logic [1:0] rails);
        return rails[1];
    endfunction

endpackage
`default_nettype wire

// File: rtl/twod_counter_digit_cells.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | th12 / thnotn                                                        |
// | Leaf cells of the counter chain: completion OR and inverting source. |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module th12 (
    input  logic a,
    input  logic b,
    output logic y
);
    assign y = a | b;
endmodule

module thnotn (
    input  logic a,
    input  logic init,
    output logic y
);
    // Requests DATA whenever the downstream ack is low and the chain is out of reset.
    assign y = ~a & ~init;
endmodule
`default_nettype wire

// File: rtl/twod_counter_digit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | twod_counter_digit                                                   |
// | One dual-rail digit of a four-phase ripple counter.                  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module twod_counter_digit
    import twod_counter_digit_pkg::*;
(
    input  logic       clk,
    input  logic       init,
    output logic [1:0] sum,
    input  logic       sumcomp,
    output logic [1:0] carryout,
    input  logic       carryoutcomp,
    input  logic [1:0] carryin,
    output logic       carryincomp
);

    phase_t     r_phase, w_phase_nxt;
    logic       r_d, w_d_nxt;
    logic [1:0] r_sum, w_sum_nxt;
    logic [1:0] r_co, w_co_nxt;
    logic       r_cic, w_cic_nxt;
    logic       w_c;

    assign w_c = rail_val(carryin);

    always_ff @(posedge clk or posedge init) begin
        if (init) begin
            r_phase <= NULL_PH;
            r_d     <= 1'b0;
            r_sum   <= NULL_V;
            r_co    <= NULL_V;
            r_cic   <= 1'b0;
        end else begin
            r_phase <= w_phase_nxt;
            r_d     <= w_d_nxt;
            r_sum   <= w_sum_nxt;
            r_co    <= w_co_nxt;
            r_cic   <= w_cic_nxt;
        end
    end

    always_comb begin
        w_phase_nxt = r_phase;
        w_d_nxt     = r_d;
        w_sum_nxt   = r_sum;
        w_co_nxt    = r_co;
        w_cic_nxt   = r_cic;
        case (r_phase)
            NULL_PH: begin
                // The digit updates only on this edge, so a held DATA input counts once.
                if (is_data(carryin) && !sumcomp && !carryoutcomp) begin
                    w_phase_nxt = DATA_PH;
                    w_d_nxt     = r_d ^ w_c;
                    w_sum_nxt   = (r_d ^ w_c) ? D1 : D0;
                    w_co_nxt    = (r_d & w_c) ? D1 : D0;
                    w_cic_nxt   = 1'b1;
                end
            end
            DATA_PH: begin
                if ((carryin == NULL_V) && sumcomp && carryoutcomp) begin
                    w_phase_nxt = NULL_PH;
                    w_sum_nxt   = NULL_V;
                    w_co_nxt    = NULL_V;
                    w_cic_nxt   = 1'b0;
                end
            end
            default: w_phase_nxt = NULL_PH;
        endcase
    end

    assign sum         = r_sum;
    assign carryout    = r_co;
    assign carryincomp = r_cic;

endmodule
`default_nettype wire

// File: tb/tb_twod_counter_digit.sv
`default_nettype none
// Bench for twod_counter_digit: single-digit scoreboard checks plus a
// 32-stage self-driven chain whose decoded count must step by one.
module tb_twod_counter_digit;

    localparam int NST = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // ---------------- single digit ----------------
    logic       init;
    logic [1:0] sum0, co0, cin0;
    logic       sc0, coc0, cic0, coc_th, bp_en, bp_val;

    twod_counter_digit u_dig (
        .clk(clk), .init(init), .sum(sum0), .sumcomp(sc0),
        .carryout(co0), .carryoutcomp(coc0), .carryin(cin0), .carryincomp(cic0)
    );
    th12 u_sc0 (.a(sum0[1]), .b(sum0[0]), .y(sc0));
    th12 u_co0 (.a(co0[1]),  .b(co0[0]),  .y(coc_th));
    assign coc0 = bp_en ? bp_val : coc_th;

    // ---------------- 32-stage chain ----------------
    logic                 cinit;
    logic [NST:0][1:0]    ch_carry;
    logic [NST-1:0][1:0]  ch_sum;
    logic [NST-1:0]       ch_sc, ch_coc, ch_cic;
    logic                 last_coc;

    thnotn u_src (.a(ch_cic[0]), .init(cinit), .y(ch_carry[0][1]));
    assign ch_carry[0][0] = 1'b0;
    th12 u_last (.a(ch_carry[NST][1]), .b(ch_carry[NST][0]), .y(last_coc));

    generate
        for (genvar i = 0; i < NST; i++) begin : g_chain
            th12 u_sc (.a(ch_sum[i][1]), .b(ch_sum[i][0]), .y(ch_sc[i]));
            if (i == NST - 1) begin : g_last
                assign ch_coc[i] = last_coc;
            end else begin : g_mid
                assign ch_coc[i] = ch_cic[i+1];
            end
            twod_counter_digit u_d (
                .clk(clk), .init(cinit), .sum(ch_sum[i]), .sumcomp(ch_sc[i]),
                .carryout(ch_carry[i+1]), .carryoutcomp(ch_coc[i]),
                .carryin(ch_carry[i]), .carryincomp(ch_cic[i])
            );
        end
    endgenerate

    // Chain monitor: each stage's DATA bit is filed under its own wavefront index,
    // and the word is complete when the last stage fires for that index.
    logic [31:0] obs_q[$];
    initial begin : mon
        int          cnt[NST];
        logic [31:0] acc[64];
        logic [NST-1:0] prev;
        prev = '0;
        for (int i = 0; i < NST; i++) cnt[i] = 0;
        forever begin
            @(negedge clk);
            if (cinit) begin
                prev = '0;
                for (int i = 0; i < NST; i++) cnt[i] = 0;
            end else begin
                for (int i = 0; i < NST; i++) begin
                    if (ch_cic[i] && !prev[i]) begin
                        acc[cnt[i] % 64][i] = ch_sum[i][1];
                        if (i == NST - 1) obs_q.push_back(acc[cnt[i] % 64]);
                        cnt[i]++;
                    end
                end
                prev = ch_cic;
            end
        end
    end

    // ---------------- helpers ----------------
    logic [4:0] exp_q[$];
    logic       m_d;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag);
        logic [4:0] e, g;
        tick();
        g = {sum0, co0, cic0};
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $error("FAIL %s: scoreboard empty, got=%b", tag, g);
        end else begin
            e = exp_q.pop_front();
            assert (g === e) else begin
                bad++;
                $error("FAIL %s: got sum/co/cic=%b expected=%b", tag, g, e);
            end
        end
    endtask

    task automatic wave(input logic c);
        logic [4:0] e;
        cin0 = c ? 2'b10 : 2'b01;
        e = {((m_d ^ c) ? 2'b10 : 2'b01), ((m_d & c) ? 2'b10 : 2'b01), 1'b1};
        m_d = m_d ^ c;
        exp_q.push_back(e);
        check("data");
        exp_q.push_back(e);
        check("hold");
        exp_q.push_back(e);
        check("hold");
        cin0 = 2'b00;
        exp_q.push_back(5'b0);
        check("null");
    endtask

    task automatic wait_obs(input int k);
        int n;
        logic [31:0] v;
        n = 0;
        while (obs_q.size() == 0 && n < 3000) begin
            @(posedge clk);
            n++;
        end
        total++;
        if (obs_q.size() == 0) begin
            bad++;
            $error("FAIL chain_timeout: no count word, expected=%0d", k);
        end else begin
            v = obs_q.pop_front();
            assert (v === 32'(k)) else begin
                bad++;
                $error("FAIL chain_count: got=%0d expected=%0d", v, k);
            end
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        init   = 1'b1;
        cinit  = 1'b1;
        cin0   = 2'b00;
        bp_en  = 1'b0;
        bp_val = 1'b0;
        m_d    = 1'b0;

        for (int k = 0; k < 3; k++) begin
            cin0 = 2'($urandom);
            exp_q.push_back(5'b0);
            check("reset");
        end
        cin0 = 2'b00;
        init = 1'b0;
        for (int k = 0; k < 3; k++) begin
            exp_q.push_back(5'b0);
            check("idle");
        end

        wave(1'b1);   // d 0->1: sum 1, carry 0
        wave(1'b1);   // d 1->0 wrap: sum 0, carry 1
        wave(1'b1);   // d 0->1
        wave(1'b0);   // carry-0 wavefront keeps d=1
        wave(1'b1);   // proves d was still 1

        bp_en  = 1'b1;
        bp_val = 1'b1;
        cin0   = 2'b10;
        for (int k = 0; k < 20; k++) begin
            exp_q.push_back(5'b0);
            check("backpressure");
        end
        bp_val = 1'b0;
        exp_q.push_back({((m_d ^ 1'b1) ? 2'b10 : 2'b01), ((m_d & 1'b1) ? 2'b10 : 2'b01), 1'b1});
        m_d = m_d ^ 1'b1;
        check("bp_release");
        bp_en = 1'b0;
        cin0  = 2'b00;
        exp_q.push_back(5'b0);
        check("bp_null");
        wave(1'b1);   // only one increment happened under backpressure

        // chain counting
        @(posedge clk);
        #1;
        cinit = 1'b0;
        for (int k = 1; k <= 12; k++) wait_obs(k);

        // asynchronous reset in the middle of a ripple
        @(posedge clk);
        #3;
        cinit = 1'b1;
        #1;
        total++;
        assert (ch_sum === '0) else begin
            bad++;
            $error("FAIL midreset_sum: got=%h expected=0", ch_sum);
        end
        total++;
        assert (ch_carry[NST:1] === '0) else begin
            bad++;
            $error("FAIL midreset_carry: got=%h expected=0", ch_carry[NST:1]);
        end
        total++;
        assert (ch_cic === '0) else begin
            bad++;
            $error("FAIL midreset_cic: got=%h expected=0", ch_cic);
        end
        tick();
        tick();
        obs_q.delete();
        cinit = 1'b0;
        for (int k = 1; k <= 5; k++) wait_obs(k);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
